// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: sync, active-video flag, coordinates,
// line/frame strobes and a completed-frame counter, all registered and aligned.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int FRAME_W   = 8,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input  logic               pclk,
  input  logic               reset,
  input  logic               pix_en,
  output logic               hsync,
  output logic               vsync,
  output logic               valid,
  output logic [HW-1:0]      h_cnt,
  output logic [VW-1:0]      v_cnt,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam logic [HW-1:0] H_MAX = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_MAX = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_LO = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_HI = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_ACT = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_LO = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_HI = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] hc, hc_n;
  logic [VW-1:0] vc, vc_n;
  logic          first;
  logic          line_tick, frame_tick;

  always_comb begin
    hc_n = hc;
    vc_n = vc;
    if (pix_en) begin
      if (hc == H_MAX) begin
        hc_n = '0;
        vc_n = (vc == V_MAX) ? '0 : vc + 1'b1;
      end else begin
        hc_n = hc + 1'b1;
      end
    end
  end

  // Strobes fire only on a tick that moves onto x=0, never on a held position.
  assign line_tick  = pix_en && (hc_n == '0);
  assign frame_tick = line_tick && (vc_n == '0);

  // Outputs decode the next-state counters so they land on the same edge.
  always_ff @(posedge pclk) begin
    if (reset) begin
      hc          <= H_MAX;
      vc          <= V_MAX;
      first       <= 1'b1;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      valid       <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      hc          <= hc_n;
      vc          <= vc_n;
      hsync       <= (hc_n >= HS_LO && hc_n < HS_HI) ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= (vc_n >= VS_LO && vc_n < VS_HI) ? VSYNC_POL : ~VSYNC_POL;
      valid       <= (hc_n < H_ACT) && (vc_n < V_ACT);
      h_cnt       <= (hc_n < H_ACT) ? hc_n : '0;
      v_cnt       <= (vc_n < V_ACT) ? vc_n : '0;
      line_start  <= line_tick;
      frame_start <= frame_tick;
      if (pix_en) first <= 1'b0;
      // The entry into (0,0) straight out of reset is not a completed frame.
      if (frame_tick && !first) frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule
